main_memory_responder: RTL and testbench
========================================

Name: main_memory_responder

Overview:
- Word-addressed main-memory model that answers the cache controller's memory port.
- Accepts pipelined read requests through a valid/ready address handshake and returns data a fixed latency later as one-cycle valid pulses, in order.
- Performs single-cycle posted writes.
- Periodically blocks new read requests to model refresh.
- Sits between cache_controller and the testbench/top level; it is the only backing store.

Parameters:
- ADDR_WIDTH, 32, width of word address on memory_addr
- WORD_WIDTH, 32, data word width
- DEPTH, 4096, words in storage array; power of two
- READ_LATENCY, 4, clock edges from request acceptance to data valid; >=1
- MAX_OUTSTANDING, 4, maximum reads in flight; 1..READ_LATENCY
- REFRESH_INTERVAL, 256, SERVE cycles between refreshes; 0 disables refresh
- REFRESH_CYCLES, 8, cycles ready is held low per refresh; >=1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- memory_addr  in  ADDR_WIDTH  word address for read request or write
- memory_write_en  in  1  write strobe; one word written per high cycle
- memory_write_data  in  WORD_WIDTH  write data
- memory_read_addr_valid  in  1  read request present on memory_addr
- memory_read_ready  out  1  responder can accept a read request this cycle (registered)
- memory_read_valid  out  1  memory_read_data valid this cycle (one-cycle pulse per request)
- memory_read_data  out  WORD_WIDTH  returned read word
- refresh_busy  out  1  high while in REFRESH state

Behaviour:
- Reset (async, rst=0):
  - memory_read_ready=0, memory_read_valid=0, memory_read_data=0, refresh_busy=0.
  - Pipeline valids cleared, outstanding=0, refresh counter=0, state=SERVE.
  - Array contents are not reset.
  - Reset mid-operation drops all in-flight reads silently; no valid pulses are issued for them.
  - First cycle after reset release: ready=0. Second cycle: ready=1.
- Array index: memory_addr[log2(DEPTH)-1:0]. Upper bits are ignored, so addresses alias.
- Read acceptance: occurs on a clock edge where memory_read_addr_valid & memory_read_ready. Each accepting edge is one request. A requester holding valid high across N ready cycles issues N requests.
- Latency: a request accepted at edge E produces memory_read_valid=1 during the cycle after edge E+READ_LATENCY-1. Responses are in acceptance order.
  - Pipeline: READ_LATENCY stages of {valid, index}.
  - The array is read when an entry leaves the last stage; data and valid are registered.
- No response backpressure: valid is never held or repeated.
- Outstanding counter:
  - outstanding_next = outstanding + accept - retire, where retire = the last stage is valid.
  - Simultaneous accept and retire leaves it unchanged.
- Ready register: memory_read_ready <= (next_state==SERVE) && (outstanding_next < MAX_OUTSTANDING).
  - With MAX_OUTSTANDING==READ_LATENCY, back-to-back acceptance every cycle is sustained.
- Write: on any edge with memory_write_en=1, array[index] <= memory_write_data, regardless of state or ready. Writes are never refused.
- Same-cycle write and read-request to the same index: the write is applied first, and the read later returns the new data. Any write landing before the array read at pipeline exit is visible to that read.
- Same-cycle write and pipeline-exit read to the same index: the returned data is the new write data (write-first bypass).
- State machine, two states:
  - SERVE: the refresh counter increments each cycle. When REFRESH_INTERVAL!=0 and counter==REFRESH_INTERVAL-1, go to REFRESH and clear the counter.
  - REFRESH: refresh_busy=1 and ready is driven 0. In-flight reads keep draining and returning on schedule. After REFRESH_CYCLES cycles, return to SERVE.
  - Ready is lowered on the same edge that enters REFRESH, so no request is accepted in the first REFRESH cycle.
- Counter widths: outstanding needs $clog2(MAX_OUTSTANDING+1) bits. The refresh counter is sized for max(REFRESH_INTERVAL, REFRESH_CYCLES). No wrap occurs within legal parameter ranges.

Decomposition:
- Package mem_resp_pkg:
  - state enum {SERVE, REFRESH}
  - req_stage_t struct {valid, index}
  - localparam IDX_W = $clog2(DEPTH)
- One sub-module: mem_resp_pipe.
  - Parameterised READ_LATENCY shift register of req_stage_t.
  - Outputs the exit entry.
- Array, bypass, outstanding counter and FSM stay in main_memory_responder.

Test Plan:
- Reset then single read:
  - Preload array[0x10]=0xDEADBEEF; assert valid with addr 0x10 for exactly one ready cycle at edge E.
  - Expect one memory_read_valid pulse with data 0xDEADBEEF after edge E+3 (READ_LATENCY=4), and no other pulses.
- Burst of 8:
  - Hold valid high with addr 0x40..0x47, incrementing on each accepted edge.
  - Expect ready to stay 1 continuously (MAX_OUTSTANDING=4).
  - Expect 8 consecutive valid pulses, in order, carrying array[0x40..0x47].
- Throttle: with MAX_OUTSTANDING=2, READ_LATENCY=4, hold valid.
  - Expect ready low whenever outstanding==2.
  - Expect accepts spaced so no more than 2 in flight; all responses in order with correct data.
- Write-then-read hazard:
  - Same cycle: write 0x12345678 to addr 0x20 and read request to addr 0x20. Expect returned data 0x12345678.
  - Write 0xA5A5A5A5 to 0x20 two cycles after that read is accepted. Expect it is also returned (write lands before exit).
- Refresh: with REFRESH_INTERVAL=16, REFRESH_CYCLES=8, hold valid continuously.
  - Expect refresh_busy high and ready low for exactly 8 cycles after 16 SERVE cycles.
  - Expect in-flight reads still returned during refresh; no requests accepted during refresh.
- Reset mid-burst:
  - Assert rst=0 with 3 reads in flight.
  - Expect all outputs 0 immediately and no valid pulses after release.
  - Expect ready=1 on the second cycle after release; array contents preserved.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types for the main-memory responder: FSM states and the
// read-request pipeline entry.
package mem_resp_pkg;

    localparam int MEM_DEPTH = 4096;
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic {
        SERVE,
        REFRESH
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
    } req_stage_t;

endpackage

// File: rtl/main_memory_responder_if.sv
// Memory port between the cache controller (master) and the
// main-memory responder (slave).
interface main_memory_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0] memory_addr;
    logic                  memory_write_en;
    logic [WORD_WIDTH-1:0] memory_write_data;
    logic                  memory_read_addr_valid;
    logic                  memory_read_ready;
    logic                  memory_read_valid;
    logic [WORD_WIDTH-1:0] memory_read_data;
    logic                  refresh_busy;

    modport master (
        output memory_addr,
        output memory_write_en,
        output memory_write_data,
        output memory_read_addr_valid,
        input  memory_read_ready,
        input  memory_read_valid,
        input  memory_read_data,
        input  refresh_busy
    );

    modport slave (
        input  memory_addr,
        input  memory_write_en,
        input  memory_write_data,
        input  memory_read_addr_valid,
        output memory_read_ready,
        output memory_read_valid,
        output memory_read_data,
        output refresh_busy
    );

endinterface

// File: rtl/mem_resp_pipe.sv
// Read-request delay line; stage 0 is the incoming request itself, so
// the exit entry is read out READ_LATENCY-1 edges after acceptance.
module mem_resp_pipe
    import mem_resp_pkg::*;
#(
    parameter int READ_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  req_stage_t req,
    output req_stage_t exit_e
);

    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign exit_e = req;
        end else begin : g_shift
            req_stage_t stg [1:READ_LATENCY-1];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 1; i < READ_LATENCY; i++) begin
                        stg[i] <= '0;
                    end
                end else begin
                    stg[1] <= req;
                    for (int i = 2; i < READ_LATENCY; i++) begin
                        stg[i] <= stg[i-1];
                    end
                end
            end

            assign exit_e = stg[READ_LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/main_memory_responder.sv
// Word-addressed backing store with pipelined fixed-latency reads,
// posted writes and periodic refresh stalls.
module main_memory_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter int WORD_WIDTH       = 32,
    parameter int DEPTH            = 4096,
    parameter int READ_LATENCY     = 4,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int REFRESH_INTERVAL = 256,
    parameter int REFRESH_CYCLES   = 8
) (
    input logic                    clk,
    input logic                    rst,
    main_memory_responder_if.slave mem
);

    localparam int IW   = $clog2(DEPTH);
    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int CMAX = (REFRESH_INTERVAL > REFRESH_CYCLES) ?
                          REFRESH_INTERVAL : REFRESH_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [OW-1:0]         outstanding, outstanding_n;
    logic                  ready_q, ready_n;
    logic                  valid_q;
    logic [WORD_WIDTH-1:0] data_q, rd_data;
    logic                  accept, retire;
    logic [IW-1:0]         idx, exit_idx;
    req_stage_t            req, exit_e;
    logic                  unused_addr;

    assign idx         = mem.memory_addr[IW-1:0];
    assign unused_addr = ^mem.memory_addr[ADDR_WIDTH-1:IW];
    assign accept      = mem.memory_read_addr_valid & ready_q;
    assign req         = '{valid: accept, index: IDX_W'(idx)};

    mem_resp_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .exit_e (exit_e)
    );

    assign retire   = exit_e.valid;
    assign exit_idx = exit_e.index[IW-1:0];

    // A write on the exit edge must win over the stale array word.
    assign rd_data = (mem.memory_write_en && idx == exit_idx) ?
                     mem.memory_write_data : mem_q[exit_idx];

    assign outstanding_n = outstanding + OW'(accept) - OW'(retire);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        unique case (state)
            SERVE: begin
                if (REFRESH_INTERVAL == 0) begin
                    cnt_n = cnt;
                end else if (cnt == CW'(REFRESH_INTERVAL - 1)) begin
                    state_n = REFRESH;
                    cnt_n   = '0;
                end
            end
            REFRESH: begin
                if (cnt == CW'(REFRESH_CYCLES - 1)) begin
                    state_n = SERVE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = SERVE;
                cnt_n   = '0;
            end
        endcase
    end

    assign ready_n = (state_n == SERVE) &&
                     (outstanding_n < OW'(MAX_OUTSTANDING));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SERVE;
            cnt         <= '0;
            outstanding <= '0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            outstanding <= outstanding_n;
            ready_q     <= ready_n;
            valid_q     <= retire;
            if (retire) begin
                data_q <= rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem.memory_write_en) begin
            mem_q[idx] <= mem.memory_write_data;
        end
    end

    assign mem.memory_read_ready = ready_q;
    assign mem.memory_read_valid = valid_q;
    assign mem.memory_read_data  = data_q;
    assign mem.refresh_busy      = (state == REFRESH);

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench: u0 default-latency/no-refresh, u1 refresh every 16,
// u2 throttled to two outstanding reads.
module tb_main_memory_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    main_memory_responder_if m0 ();
    main_memory_responder_if m1 ();
    main_memory_responder_if m2 ();

    main_memory_responder #(
        .REFRESH_INTERVAL (0)
    ) u0 (
        .clk (clk),
        .rst (rst),
        .mem (m0)
    );

    main_memory_responder #(
        .REFRESH_INTERVAL (16),
        .REFRESH_CYCLES   (8)
    ) u1 (
        .clk (clk),
        .rst (rst),
        .mem (m1)
    );

    main_memory_responder #(
        .MAX_OUTSTANDING  (2),
        .REFRESH_INTERVAL (0)
    ) u2 (
        .clk (clk),
        .rst (rst),
        .mem (m2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr0(input logic [31:0] a, input logic [31:0] d);
        m0.memory_addr       = a;
        m0.memory_write_data = d;
        m0.memory_write_en   = 1'b1;
        tick();
        m0.memory_write_en   = 1'b0;
    endtask

    // Read 0x20 at edge E; optional second write at edge E+wk.
    task automatic hz(input string tag, input logic [31:0] ds,
                      input int wk, input logic [31:0] dl,
                      input logic [31:0] exp);
        for (int j = 0; j < 4; j++) begin
            m0.memory_addr            = 32'h20;
            m0.memory_write_en        = (j == 0) || (j == wk);
            m0.memory_write_data      = (j == 0) ? ds : dl;
            m0.memory_read_addr_valid = (j == 0);
            tick();
        end
        m0.memory_write_en        = 1'b0;
        m0.memory_read_addr_valid = 1'b0;
        chk({tag, "_valid"}, 32'(m0.memory_read_valid), 32'd1);
        chk(tag, m0.memory_read_data, exp);
    endtask

    task automatic rd0(input string tag, input logic [31:0] a,
                       input logic [31:0] exp);
        m0.memory_addr            = a;
        m0.memory_read_addr_valid = 1'b1;
        tick();
        m0.memory_read_addr_valid = 1'b0;
        repeat (3) tick();
        chk({tag, "_valid"}, 32'(m0.memory_read_valid), 32'd1);
        chk(tag, m0.memory_read_data, exp);
    endtask

    initial begin
        int n1, p1, a1, bc, fb, vb, rb;
        int n2, p2, a2, mx;
        logic acc1, acc2, acc;
        int i, pc, first, last;

        m0.memory_addr = '0;
        m0.memory_write_en = 1'b0;
        m0.memory_write_data = '0;
        m0.memory_read_addr_valid = 1'b0;
        m1.memory_addr = '0;
        m1.memory_write_en = 1'b0;
        m1.memory_write_data = '0;
        m1.memory_read_addr_valid = 1'b0;
        m2.memory_addr = '0;
        m2.memory_write_en = 1'b0;
        m2.memory_write_data = '0;
        m2.memory_read_addr_valid = 1'b0;

        #1;
        chk("rst_ready", 32'(m0.memory_read_ready), 32'd0);
        chk("rst_valid", 32'(m0.memory_read_valid), 32'd0);
        chk("rst_data", m0.memory_read_data, 32'd0);
        chk("rst_busy", 32'(m0.refresh_busy), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rel_ready0", 32'(m0.memory_read_ready), 32'd0);
        chk("rel_ready2", 32'(m2.memory_read_ready), 32'd0);

        // Refresh on u1 and throttling on u2, run side by side.
        n1 = 0; p1 = 0; a1 = 0; bc = 0; fb = 0; vb = 0; rb = 0;
        n2 = 0; p2 = 0; a2 = 0; mx = 0;
        for (int k = 1; k <= 36; k++) begin
            m1.memory_read_addr_valid = (k <= 30);
            m1.memory_write_en        = (k <= 30);
            m1.memory_addr            = 32'(n1);
            m1.memory_write_data      = 32'hB000_0000 + 32'(n1);
            m2.memory_read_addr_valid = (k <= 30);
            m2.memory_write_en        = (k <= 30);
            m2.memory_addr            = 32'(n2);
            m2.memory_write_data      = 32'hC0DE_0000 + 32'(n2);
            acc1 = m1.memory_read_ready & m1.memory_read_addr_valid;
            acc2 = m2.memory_read_ready & m2.memory_read_addr_valid;
            tick();
            if (acc1) begin a1++; n1++; end
            if (acc2) begin a2++; n2++; end
            if (m1.memory_read_valid) begin
                chk("ref_data", m1.memory_read_data,
                    32'hB000_0000 + 32'(p1));
                p1++;
                if (m1.refresh_busy) vb++;
            end
            if (m1.refresh_busy) begin
                bc++;
                if (fb == 0) fb = k;
                if (m1.memory_read_ready) rb++;
            end
            if (m2.memory_read_valid) begin
                chk("thr_data", m2.memory_read_data,
                    32'hC0DE_0000 + 32'(p2));
                p2++;
            end
            if (a2 - p2 > mx) mx = a2 - p2;
        end
        chk("ref_busy_cycles", 32'(bc), 32'd8);
        chk("ref_busy_start", 32'(fb), 32'd16);
        chk("ref_pulses_in_busy", 32'(vb), 32'd4);
        chk("ref_ready_in_busy", 32'(rb), 32'd0);
        chk("ref_accepts", 32'(a1), 32'd21);
        chk("ref_responses", 32'(p1), 32'd21);
        chk("thr_accepts", 32'(a2), 32'd15);
        chk("thr_responses", 32'(p2), 32'd15);
        chk("thr_max_inflight", 32'(mx), 32'd2);

        wr0(32'h10, 32'hDEAD_BEEF);
        for (int j = 0; j < 8; j++) begin
            wr0(32'h40 + 32'(j), 32'h1000_0040 + 32'(j));
        end

        m0.memory_addr = 32'h10;
        m0.memory_read_addr_valid = 1'b1;
        chk("single_ready", 32'(m0.memory_read_ready), 32'd1);
        tick();
        m0.memory_read_addr_valid = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk("single_valid", 32'(m0.memory_read_valid), 32'(j == 3));
            if (j == 3) chk("single_data", m0.memory_read_data,
                            32'hDEAD_BEEF);
        end

        i = 0; pc = 0; first = -1; last = -1;
        m0.memory_addr = 32'h40;
        m0.memory_read_addr_valid = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            if (i < 8) chk("burst_ready", 32'(m0.memory_read_ready), 32'd1);
            acc = m0.memory_read_ready & m0.memory_read_addr_valid;
            tick();
            if (acc) begin
                i++;
                m0.memory_addr = 32'h40 + 32'(i);
                if (i == 8) m0.memory_read_addr_valid = 1'b0;
            end
            if (m0.memory_read_valid) begin
                chk("burst_data", m0.memory_read_data,
                    32'h1000_0040 + 32'(pc));
                if (first < 0) first = c;
                last = c;
                pc++;
            end
        end
        chk("burst_count", 32'(pc), 32'd8);
        chk("burst_span", 32'(last - first + 1), 32'd8);

        hz("hz_same", 32'h1234_5678, -1, 32'h0, 32'h1234_5678);
        hz("hz_late", 32'h1111_1111, 2, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        hz("hz_bypass", 32'h2222_2222, 3, 32'h5A5A_5A5A, 32'h5A5A_5A5A);

        m0.memory_addr = 32'h40;
        m0.memory_read_addr_valid = 1'b1;
        repeat (3) tick();
        m0.memory_read_addr_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(m0.memory_read_ready), 32'd0);
        chk("mid_rst_valid", 32'(m0.memory_read_valid), 32'd0);
        chk("mid_rst_data", m0.memory_read_data, 32'd0);
        chk("mid_rst_busy", 32'(m0.refresh_busy), 32'd0);
        tick();
        rst = 1'b1;
        chk("rel2_ready0", 32'(m0.memory_read_ready), 32'd0);
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk("post_rst_valid", 32'(m0.memory_read_valid), 32'd0);
            if (j == 1) chk("rel2_ready1", 32'(m0.memory_read_ready), 32'd1);
        end
        rd0("kept_0x10", 32'h10, 32'hDEAD_BEEF);
        rd0("kept_0x47", 32'h47, 32'h1000_0047);
        rd0("alias_0x1010", 32'h1010, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
